qea_host_sequencer: RTL
=======================

// Module: qea_host_sequencer
// PURPOSE
// Host-side sequencer directly upstream of QEA: one job = load gate contexts into QEA ctx RAM,
// initialise state RAM to |0...0>, pulse start, wait for completion, stream the final state
// vector back to the host. Replaces the bench-driven load/start/readout sequence with
// synthesizable control; reports execution cycle count per job.
// PARAMETERS
// PE_NUM_WIDTH             2   log2(PE_NUM)
// PE_NUM                   4   processing elements; one state word holds PE_NUM amplitudes
// DATA_WIDTH              32   real/imag component width, fixed point
// NUM_FRAC_BIT            30   fraction bits; 1.0 = 1<<NUM_FRAC_BIT
// MAX_QBIT_WIDTH           6   width of qubit-count field
// STATE_DATA_WIDTH        64   DATA_WIDTH*2, {real,imag} per amplitude
// STATE_ADDR_WIDTH        16   state RAM address width
// GATE_CONTEXT_DATA_WIDTH 64   context word width
// GATE_CONTEXT_ADDR_WIDTH 16   context RAM address width
// RD_LAT                   1   state RAM read latency (cycles, 1..4)
// PORTS
// clk              in   1                   clock
// rst_n            in   1                   reset, synchronous, active-low
// i_cfg_valid      in   1                   job request
// o_cfg_ready      out  1                   high only in IDLE
// i_cfg_qbit_num   in   MAX_QBIT_WIDTH      qubits for job
// i_cfg_ins_num    in   GATE_CONTEXT_ADDR_WIDTH+1  context words to load (0 = keep old ctx)
// i_ctx_valid/o_ctx_ready in/out 1          context word stream handshake
// i_ctx_data       in   GATE_CONTEXT_DATA_WIDTH  context word
// o_res_valid/i_res_ready out/in 1          result stream handshake
// o_res_data       out  PE_NUM*STATE_DATA_WIDTH  state word, address order
// o_res_last       out  1                   marks final state word
// o_busy           out  1                   not IDLE
// o_done           out  1                   1-cycle pulse after last result accepted
// o_err            out  1                   1-cycle pulse on rejected config
// o_cycle_cnt      out  32                  cycles from start pulse to complete seen
// o_qea_start      out  1                   to QEA i_start
// o_qea_qbit_num   out  MAX_QBIT_WIDTH      to QEA i_qbit_num, registered at cfg accept
// o_ctx_en/o_ctx_wea out 1                  to QEA ctx port
// o_ctx_addr       out  GATE_CONTEXT_ADDR_WIDTH
// o_ctx_data       out  GATE_CONTEXT_DATA_WIDTH
// o_state_ena/o_state_wea out 1             to QEA state port
// o_state_addra    out  STATE_ADDR_WIDTH
// o_state_dina     out  PE_NUM*STATE_DATA_WIDTH
// i_qea_complete   in   1                   QEA o_complete (level)
// i_qea_state_dout in   PE_NUM*STATE_DATA_WIDTH  QEA o_state_dout
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): FSM->IDLE, all outputs 0 except o_cfg_ready=1, o_qea_qbit_num=0; mid-job reset aborts, no further result beats, in-flight reads discarded.
// - FSM: IDLE->LOAD_CTX->INIT_STATE->START->WAIT->READ->IDLE.
// - IDLE: accept on i_cfg_valid&o_cfg_ready. N=2**(qbit_num-PE_NUM_WIDTH). Reject (o_err, stay IDLE) if qbit_num<=PE_NUM_WIDTH or qbit_num-PE_NUM_WIDTH>STATE_ADDR_WIDTH or ins_num>2**GATE_CONTEXT_ADDR_WIDTH.
// - LOAD_CTX (skipped if ins_num=0): o_ctx_ready=1; each accepted word drives ctx_en=wea=1, addr 0,1,..., data same cycle (registered, 1-cycle latency). Exit after ins_num words; stalls indefinitely on i_ctx_valid=0.
// - INIT_STATE: N consecutive cycles, ena=wea=1, addr 0..N-1; word 0 = 1.0+0j in top PE slot (bits [PE_NUM*64-1 -: 32]=1<<NUM_FRAC_BIT), all other bits/words 0.
// - START: o_qea_start=1 exactly one cycle; o_cycle_cnt cleared to 0 that cycle.
// - WAIT: o_cycle_cnt +1 per cycle (saturate at 2^32-1); i_qea_complete ignored on first WAIT cycle (stale level), exit on first later cycle with complete=1; count then frozen until next START.
// - READ: ena=1, wea=0 always. Read issued only if outstanding+FIFO occupancy < RD_LAT+2; returned data captured RD_LAT cycles after issue into (RD_LAT+2)-deep FIFO; FIFO head drives o_res_*. o_res_data/last stable while valid&!ready. o_res_last on word N-1. o_done the cycle after last beat accepted; then IDLE.
// - Full throughput: with i_res_ready held 1, one beat per cycle after RD_LAT fill.
// - i_ctx_valid ignored outside LOAD_CTX; i_cfg_valid ignored when busy.
// TESTING
// - 11 qubits, ins_num=353, ctx valid every cycle -> 353 ctx writes addr 0..352 back-to-back, then 512 init writes, word0=64'h40000000_00000000 in top slot.
// - Stub QEA raises complete 100 cycles after start -> o_cycle_cnt=100; complete already high at START ignored on first WAIT cycle.
// - Readout, stub dout=f(addr), res_ready toggling 1/0 -> 512 beats, in order, no loss/dup, last only on beat 511, o_done 1 cycle later.
// - cfg qbit_num=2 (PE_NUM_WIDTH=2) -> o_err pulse, no QEA port activity, o_cfg_ready stays 1.
// - ins_num=0, qbit_num=3 -> no ctx writes, 2 init writes, 2 result beats.
// - rst_n=0 mid-READ with beats pending -> next cycle o_res_valid=0, IDLE; new job runs cleanly.

Source files
------------

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: per-job ctx load, state init, QEA start/wait and state readout with cycle count
module qea_host_sequencer #(
   parameter int PE_NUM_WIDTH            = 2,
   parameter int PE_NUM                  = 4,
   parameter int DATA_WIDTH              = 32,
   parameter int NUM_FRAC_BIT            = 30,
   parameter int MAX_QBIT_WIDTH          = 6,
   parameter int STATE_DATA_WIDTH        = 64,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_CONTEXT_DATA_WIDTH = 64,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int RD_LAT                  = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_cfg_valid,
   output logic                                 o_cfg_ready,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_cfg_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cfg_ins_num,
   input  logic                                 i_ctx_valid,
   output logic                                 o_ctx_ready,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
   output logic                                 o_res_valid,
   input  logic                                 i_res_ready,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
   output logic                                 o_res_last,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_err,
   output logic [31:0]                          o_cycle_cnt,
   output logic                                 o_qea_start,
   output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
   output logic                                 o_ctx_en,
   output logic                                 o_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
   output logic                                 o_state_ena,
   output logic                                 o_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
   input  logic                                 i_qea_complete,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);
   localparam int SW    = PE_NUM * STATE_DATA_WIDTH;
   localparam int CW    = (GATE_CONTEXT_ADDR_WIDTH > STATE_ADDR_WIDTH ? GATE_CONTEXT_ADDR_WIDTH : STATE_ADDR_WIDTH) + 1;
   localparam int DEPTH = RD_LAT + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam int FW    = $clog2(DEPTH + 1);
   localparam logic [SW-1:0] ONE_W = SW'(1) << (SW - DATA_WIDTH + NUM_FRAC_BIT);
   localparam logic [MAX_QBIT_WIDTH-1:0] QMIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
   localparam logic [MAX_QBIT_WIDTH-1:0] QMAX = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);
   localparam logic [GATE_CONTEXT_ADDR_WIDTH:0] IMAX = (GATE_CONTEXT_ADDR_WIDTH+1)'(1) << GATE_CONTEXT_ADDR_WIDTH;
   typedef enum logic [2:0] {IDLE, LOAD_CTX, INIT_STATE, START, WAIT, READ} state_t;
   state_t state_q, state_d;
   logic [MAX_QBIT_WIDTH-1:0]          qbit_q, qbit_d;
   logic [CW-1:0]                      ins_q, ins_d, n_q, n_d, cnt_q, cnt_d, beat_q, beat_d;
   logic                               ctx_en_q, ctx_en_d, first_q, first_d, err_q, err_d, done_q, done_d;
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_q, ctx_addr_d;
   logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
   logic [31:0]                        cyc_q, cyc_d;
   logic [RD_LAT-1:0]                  pipe_q, pipe_d;
   logic [SW-1:0]                      mem_q [DEPTH];
   logic [PW-1:0]                      wp_q, wp_d, rp_q, rp_d;
   logic [FW-1:0]                      fc_q, fc_d;
   logic bad, issue, cap, pop, last_beat, last_cnt;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   // reads are throttled so issued-but-unreturned words always fit in the fifo
   assign bad       = i_cfg_qbit_num <= QMIN || i_cfg_qbit_num > QMAX || i_cfg_ins_num > IMAX;
   assign issue     = state_q == READ && cnt_q < n_q && ($countones(pipe_q) + int'(fc_q) < DEPTH);
   assign cap       = pipe_q[RD_LAT-1];
   assign pop       = fc_q != '0 && i_res_ready;
   assign last_beat = beat_q == n_q - CW'(1);
   assign last_cnt  = cnt_q == (state_q == LOAD_CTX ? ins_q : n_q) - CW'(1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         qbit_q     <= '0;
         ins_q      <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         beat_q     <= '0;
         ctx_en_q   <= 1'b0;
         first_q    <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         ctx_addr_q <= '0;
         ctx_data_q <= '0;
         cyc_q      <= '0;
         pipe_q     <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         fc_q       <= '0;
      end else begin
         state_q    <= state_d;
         qbit_q     <= qbit_d;
         ins_q      <= ins_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         beat_q     <= beat_d;
         ctx_en_q   <= ctx_en_d;
         first_q    <= first_d;
         err_q      <= err_d;
         done_q     <= done_d;
         ctx_addr_q <= ctx_addr_d;
         ctx_data_q <= ctx_data_d;
         cyc_q      <= cyc_d;
         pipe_q     <= pipe_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         fc_q       <= fc_d;
      end
      if (cap) mem_q[wp_q] <= i_qea_state_dout;
   end
   always_comb begin
      state_d    = state_q;
      qbit_d     = qbit_q;
      ins_d      = ins_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      ctx_en_d   = 1'b0;
      ctx_addr_d = ctx_addr_q;
      ctx_data_d = ctx_data_q;
      cyc_d      = cyc_q;
      err_d      = 1'b0;
      done_d     = 1'b0;
      first_d    = state_q == START;
      pipe_d     = RD_LAT'({pipe_q, issue});
      wp_d       = cap ? inc(wp_q) : wp_q;
      rp_d       = pop ? inc(rp_q) : rp_q;
      fc_d       = fc_q + FW'(cap) - FW'(pop);
      beat_d     = beat_q + CW'(pop);
      case (state_q)
         IDLE: if (i_cfg_valid) begin
            err_d = bad;
            if (!bad) begin
               state_d = i_cfg_ins_num == '0 ? INIT_STATE : LOAD_CTX;
               qbit_d  = i_cfg_qbit_num;
               ins_d   = CW'(i_cfg_ins_num);
               n_d     = CW'(1) << (i_cfg_qbit_num - QMIN);
               cnt_d   = '0;
               beat_d  = '0;
            end
         end
         LOAD_CTX: if (i_ctx_valid) begin
            ctx_en_d   = 1'b1;
            ctx_addr_d = cnt_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
            ctx_data_d = i_ctx_data;
            cnt_d      = last_cnt ? '0 : cnt_q + 1'b1;
            state_d    = last_cnt ? INIT_STATE : LOAD_CTX;
         end
         INIT_STATE: begin
            cnt_d   = last_cnt ? '0 : cnt_q + 1'b1;
            state_d = last_cnt ? START : INIT_STATE;
            cyc_d   = last_cnt ? '0 : cyc_q;
         end
         START: state_d = WAIT;
         WAIT: begin
            cyc_d   = cyc_q + 32'(cyc_q != '1);
            state_d = i_qea_complete && !first_q ? READ : WAIT;
         end
         READ: begin
            cnt_d   = issue ? cnt_q + 1'b1 : cnt_q;
            done_d  = pop && last_beat;
            state_d = pop && last_beat ? IDLE : READ;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      o_cfg_ready    = state_q == IDLE;
      o_busy         = state_q != IDLE;
      o_ctx_ready    = state_q == LOAD_CTX;
      o_qea_start    = state_q == START;
      o_qea_qbit_num = qbit_q;
      o_ctx_en       = ctx_en_q;
      o_ctx_wea      = ctx_en_q;
      o_ctx_addr     = ctx_addr_q;
      o_ctx_data     = ctx_data_q;
      o_state_ena    = state_q == INIT_STATE || state_q == READ;
      o_state_wea    = state_q == INIT_STATE;
      o_state_addra  = o_state_ena ? cnt_q[STATE_ADDR_WIDTH-1:0] : '0;
      o_state_dina   = state_q == INIT_STATE && cnt_q == '0 ? ONE_W : '0;
      o_res_valid    = fc_q != '0;
      o_res_data     = o_res_valid ? mem_q[rp_q] : '0;
      o_res_last     = o_res_valid && last_beat;
      o_done         = done_q;
      o_err          = err_q;
      o_cycle_cnt    = cyc_q;
   end
endmodule
